// File: rtl/mcdf_formatter.sv
// ============================================================================
// Module   : mcdf_formatter
// Purpose  : Turns one arbitrated channel FIFO burst into a framed packet stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mcdf_formatter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        a_req_i,
    input  logic [1:0]  a_id_i,
    input  logic [31:0] a_data_i,
    output logic        a_ack_o,
    input  logic [2:0]  len_i,
    output logic        fmt_req_o,
    input  logic        fmt_grant_i,
    output logic [1:0]  fmt_chid_o,
    output logic [5:0]  fmt_length_o,
    output logic [31:0] fmt_data_o,
    output logic        fmt_val_o,
    output logic        fmt_start_o,
    output logic        fmt_end_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2,
        ST_LAST = 2'd3
    } state_t;

    state_t      state_q;
    logic [5:0]  word_cnt_q;
    logic [5:0]  word_cnt_d;
    logic [5:0]  length_q;
    logic [5:0]  length_d;
    logic [1:0]  chid_q;
    logic [31:0] data_q;
    logic        ack_q;
    logic        req_q;
    logic        val_q;
    logic        start_q;
    logic        end_q;
    logic        last_word;

    always_comb begin
        length_d = 6'd32;
        case (len_i)
            3'd0:    length_d = 6'd4;
            3'd1:    length_d = 6'd8;
            3'd2:    length_d = 6'd16;
            default: length_d = 6'd32;
        endcase
    end

    assign word_cnt_d = word_cnt_q + 6'd1;
    assign last_word  = (word_cnt_q == (length_q - 6'd1));

    // Every output is a register so downstream sees glitch-free framing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= 6'd0;
            length_q   <= 6'd0;
            chid_q     <= 2'd0;
            data_q     <= 32'd0;
            ack_q      <= 1'b0;
            req_q      <= 1'b0;
            val_q      <= 1'b0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            val_q   <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (a_req_i) begin
                        state_q  <= ST_REQ;
                        chid_q   <= a_id_i;
                        length_q <= length_d;
                        req_q    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (fmt_grant_i) begin
                        state_q    <= ST_SEND;
                        req_q      <= 1'b0;
                        ack_q      <= 1'b1;
                        word_cnt_q <= 6'd0;
                    end
                end
                ST_SEND: begin
                    // ack_q is high throughout SEND, so each cycle here pops one word.
                    data_q     <= a_data_i;
                    val_q      <= 1'b1;
                    start_q    <= (word_cnt_q == 6'd0);
                    end_q      <= last_word;
                    word_cnt_q <= word_cnt_d;
                    if (last_word) begin
                        state_q <= ST_LAST;
                        ack_q   <= 1'b0;
                    end
                end
                ST_LAST: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign a_ack_o      = ack_q;
    assign fmt_req_o    = req_q;
    assign fmt_chid_o   = chid_q;
    assign fmt_length_o = length_q;
    assign fmt_data_o   = data_q;
    assign fmt_val_o    = val_q;
    assign fmt_start_o  = start_q;
    assign fmt_end_o    = end_q;

endmodule

`default_nettype wire

// File: tb/tb_mcdf_formatter.sv
// ============================================================================
// Module   : tb_mcdf_formatter
// Purpose  : Directed self-checking bench for mcdf_formatter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mcdf_formatter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        a_req_i = 1'b0;
    logic [1:0]  a_id_i = 2'd0;
    logic [31:0] a_data_i = 32'd0;
    logic        a_ack_o;
    logic [2:0]  len_i = 3'd0;
    logic        fmt_req_o;
    logic        fmt_grant_i = 1'b0;
    logic [1:0]  fmt_chid_o;
    logic [5:0]  fmt_length_o;
    logic [31:0] fmt_data_o;
    logic        fmt_val_o;
    logic        fmt_start_o;
    logic        fmt_end_o;

    int n_chk = 0;
    int n_err = 0;
    int idx;

    mcdf_formatter u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .a_req_i      (a_req_i),
        .a_id_i       (a_id_i),
        .a_data_i     (a_data_i),
        .a_ack_o      (a_ack_o),
        .len_i        (len_i),
        .fmt_req_o    (fmt_req_o),
        .fmt_grant_i  (fmt_grant_i),
        .fmt_chid_o   (fmt_chid_o),
        .fmt_length_o (fmt_length_o),
        .fmt_data_o   (fmt_data_o),
        .fmt_val_o    (fmt_val_o),
        .fmt_start_o  (fmt_start_o),
        .fmt_end_o    (fmt_end_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] pat(input logic [1:0] id, input int i);
        pat = 32'hC0DE_0000 | (32'(id) << 12) | 32'(i);
    endfunction

    // Runs one packet starting from IDLE; FIFO head advances on each observed ack.
    task automatic run_packet(input logic [1:0] id, input logic [2:0] lc, input int gdel,
                              input int exp_len, input bit keep, input bit chg, input bit spur);
        int   nacks;
        int   words;
        int   cyc;
        logic pack;
        idx       = 0;
        a_id_i    = id;
        len_i     = lc;
        a_req_i   = 1'b1;
        a_data_i  = pat(id, 0);
        tick();
        check_eq("req_rise", fmt_req_o, 1);
        check_eq("chid", fmt_chid_o, id);
        check_eq("length", fmt_length_o, exp_len);
        check_eq("ack_in_req", a_ack_o, 0);
        if (!keep) a_req_i = 1'b0;
        for (int i = 0; i < gdel; i++) begin
            tick();
            check_eq("req_wait", fmt_req_o, 1);
            check_eq("ack_wait", a_ack_o, 0);
        end
        fmt_grant_i = 1'b1;
        tick();
        fmt_grant_i = spur;
        check_eq("req_drop", fmt_req_o, 0);
        check_eq("ack_first", a_ack_o, 1);
        nacks = 0;
        words = 0;
        cyc   = 0;
        while (words < exp_len && cyc < 80) begin
            pack = a_ack_o;
            tick();
            cyc++;
            if (pack) begin
                nacks++;
                idx++;
                a_data_i = pat(id, idx);
            end
            if (fmt_val_o) begin
                check_eq("data", fmt_data_o, pat(id, words));
                check_eq("start", fmt_start_o, (words == 0) ? 1 : 0);
                check_eq("end", fmt_end_o, (words == exp_len - 1) ? 1 : 0);
                words++;
                if (chg && words == 1) begin
                    a_id_i = 2'd0;
                    len_i  = 3'd3;
                end
            end
        end
        check_eq("timeout", (cyc < 80) ? 1 : 0, 1);
        check_eq("ack_count", nacks, exp_len);
        check_eq("word_count", words, exp_len);
        check_eq("ack_in_last", a_ack_o, 0);
        check_eq("chid_hold", fmt_chid_o, id);
        check_eq("length_hold", fmt_length_o, exp_len);
        tick();
        fmt_grant_i = 1'b0;
        check_eq("val_idle", fmt_val_o, 0);
        check_eq("end_idle", fmt_end_o, 0);
        check_eq("req_idle", fmt_req_o, 0);
        check_eq("ack_idle", a_ack_o, 0);
        check_eq("data_hold", fmt_data_o, pat(id, exp_len - 1));
    endtask

    initial begin
        int nacks;
        int cyc;
        logic pack;

        tick();
        tick();
        check_eq("rst_ack", a_ack_o, 0);
        check_eq("rst_req", fmt_req_o, 0);
        check_eq("rst_val", fmt_val_o, 0);
        check_eq("rst_start", fmt_start_o, 0);
        check_eq("rst_end", fmt_end_o, 0);
        check_eq("rst_chid", fmt_chid_o, 0);
        check_eq("rst_length", fmt_length_o, 0);
        check_eq("rst_data", fmt_data_o, 0);
        rst_i = 1'b0;
        tick();

        // Grant while idle must not start anything.
        fmt_grant_i = 1'b1;
        tick();
        tick();
        check_eq("idle_grant_req", fmt_req_o, 0);
        check_eq("idle_grant_ack", a_ack_o, 0);
        check_eq("idle_grant_val", fmt_val_o, 0);
        fmt_grant_i = 1'b0;
        tick();

        run_packet(2'd2, 3'd0, 3, 4, 0, 0, 0);
        run_packet(2'd0, 3'd1, 0, 8, 0, 0, 0);
        run_packet(2'd1, 3'd2, 1, 16, 0, 0, 0);
        run_packet(2'd2, 3'd3, 0, 32, 0, 0, 0);
        run_packet(2'd1, 3'd7, 2, 32, 0, 0, 0);

        // Back-to-back: request held, exactly one IDLE cycle between packets.
        run_packet(2'd0, 3'd1, 1, 8, 1, 0, 0);
        run_packet(2'd2, 3'd0, 0, 4, 0, 0, 0);

        run_packet(2'd1, 3'd0, 1, 4, 0, 1, 0);
        run_packet(2'd0, 3'd0, 0, 4, 0, 0, 1);

        // Reset in the middle of an 8-word packet.
        a_id_i  = 2'd1;
        len_i   = 3'd1;
        a_req_i = 1'b1;
        tick();
        a_req_i     = 1'b0;
        fmt_grant_i = 1'b1;
        tick();
        fmt_grant_i = 1'b0;
        nacks = 0;
        cyc   = 0;
        while (nacks < 2 && cyc < 20) begin
            pack = a_ack_o;
            tick();
            cyc++;
            if (pack) nacks++;
        end
        check_eq("rst_mid_reach", nacks, 2);
        check_eq("rst_mid_pre_ack", a_ack_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("rst_mid_ack", a_ack_o, 0);
        check_eq("rst_mid_req", fmt_req_o, 0);
        check_eq("rst_mid_val", fmt_val_o, 0);
        check_eq("rst_mid_start", fmt_start_o, 0);
        check_eq("rst_mid_end", fmt_end_o, 0);
        check_eq("rst_mid_chid", fmt_chid_o, 0);
        check_eq("rst_mid_length", fmt_length_o, 0);
        check_eq("rst_mid_data", fmt_data_o, 0);
        tick();
        tick();
        check_eq("rst_hold_ack", a_ack_o, 0);
        check_eq("rst_hold_end", fmt_end_o, 0);
        rst_i = 1'b0;
        tick();
        check_eq("post_rst_req", fmt_req_o, 0);
        check_eq("post_rst_ack", a_ack_o, 0);
        run_packet(2'd2, 3'd0, 1, 4, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
